branch_predict_resolve: RTL and testbench

- Parametrised successor to the EX-stage branch comparator.
- Resolves all six RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) on XLEN-wide operands.
- Adds a PC-indexed branch history table (BHT) of saturating counters. The table serves IF-stage direction prediction.
- Flags mispredictions in EX and supplies the redirect PC to the hazard/PC-select logic.

---
 rtl/branch_predict_resolve.sv | 149 ++++++++++++++
 tb/tb_branch_predict_resolve.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: EX-stage resolution of the six RV32I conditional
// branches plus a PC-indexed table of saturating counters for IF-stage
// direction prediction.
// Optional build macro: BRANCH_STATS_EN adds the resolved-branch and
// mispredict counters. When it is undefined, the stat_* outputs read 0.
module branch_predict_resolve #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_BITS    = 2,
  parameter int IDX_LSB     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_is_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred_taken,
  output logic            ex_br_taken,
  output logic            ex_mispredict,
  output logic [XLEN-1:0] ex_redirect_pc,
  input  logic            stat_clr,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  // Weakly not-taken: MSB clear, every lower bit set (0 for a 1-bit counter).
  localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

  logic                eq;
  logic                lt_s;
  logic                lt_u;
  logic                legal;
  logic                cond_taken;
  logic                res;

  logic [CNT_BITS-1:0] bht [BHT_ENTRIES];
  logic                upd_v;
  logic [IDX_W-1:0]    upd_idx;
  logic                upd_taken;
  logic [CNT_BITS-1:0] upd_cur;
  logic [CNT_BITS-1:0] upd_new;
  logic [IDX_W-1:0]    if_idx;
  logic                unused_bits;

  assign eq   = (ex_rs1 == ex_rs2);
  assign lt_s = ($signed(ex_rs1) < $signed(ex_rs2));
  assign lt_u = (ex_rs1 < ex_rs2);

  // Decode the branch condition. Reserved encodings resolve as not-taken.
  always_comb begin
    legal      = 1'b0;
    cond_taken = 1'b0;
    case (ex_funct3)
      3'b000: begin legal = 1'b1; cond_taken = eq;    end
      3'b001: begin legal = 1'b1; cond_taken = ~eq;   end
      3'b100: begin legal = 1'b1; cond_taken = lt_s;  end
      3'b101: begin legal = 1'b1; cond_taken = ~lt_s; end
      3'b110: begin legal = 1'b1; cond_taken = lt_u;  end
      3'b111: begin legal = 1'b1; cond_taken = ~lt_u; end
      default: begin legal = 1'b0; cond_taken = 1'b0; end
    endcase
  end

  assign res            = ex_valid & ex_is_branch & ~ex_stall & legal;
  assign ex_br_taken    = res & cond_taken;
  assign ex_mispredict  = res & (cond_taken != ex_pred_taken);
  assign ex_redirect_pc = cond_taken ? ex_target : (ex_pc + XLEN'(4));

  // Capture the resolved outcome. A stalled branch is captured only once,
  // in the cycle its stall drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_v     <= 1'b0;
      upd_idx   <= '0;
      upd_taken <= 1'b0;
    end else begin
      upd_v <= res;
      if (res) begin
        upd_idx   <= ex_pc[IDX_LSB +: IDX_W];
        upd_taken <= cond_taken;
      end
    end
  end

  // The read-modify-write completes within the update cycle. A following
  // update to the same index therefore reads the freshly written counter.
  assign upd_cur = bht[upd_idx];

  // Compute the saturating increment or decrement of the counter being updated.
  always_comb begin
    upd_new = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CNT_MAX) upd_new = upd_cur + CNT_BITS'(1);
    end else begin
      if (upd_cur != '0) upd_new = upd_cur - CNT_BITS'(1);
    end
  end

  // Counter table. Reset restores weakly not-taken and wins over a pending update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_RST;
    end else if (upd_v) begin
      bht[upd_idx] <= upd_new;
    end
  end

  // Prediction with write bypass. It is forced low while reset is held.
  assign if_idx        = if_pc[IDX_LSB +: IDX_W];
  assign if_pred_taken = rst_n &
                         ((upd_v && (if_idx == upd_idx)) ? upd_new[CNT_BITS-1]
                                                         : bht[if_idx][CNT_BITS-1]);

  // Only the index field of the fetch PC is consumed.
  assign unused_bits = ^{if_pc, stat_clr};

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  // Saturating event counters. Clear takes priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (res && (branch_cnt != 32'hFFFF_FFFF)) branch_cnt <= branch_cnt + 32'd1;
      if (ex_mispredict && (mispredict_cnt != 32'hFFFF_FFFF))
        mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  assign stat_branches    = branch_cnt;
  assign stat_mispredicts = mispredict_cnt;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: condition decode, counter
// saturation and bypass, stall, illegal funct3, reset of a pending update,
// and the optional statistics.
module tb_branch_predict_resolve;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_stall;
  logic        ex_is_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic        ex_pred_taken;
  logic        ex_br_taken;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
  logic        stat_clr;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int pass_cnt  = 0;
  int total_cnt = 0;

  branch_predict_resolve dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_pc           (if_pc),
    .if_pred_taken   (if_pred_taken),
    .ex_valid        (ex_valid),
    .ex_stall        (ex_stall),
    .ex_is_branch    (ex_is_branch),
    .ex_funct3       (ex_funct3),
    .ex_pc           (ex_pc),
    .ex_target       (ex_target),
    .ex_rs1          (ex_rs1),
    .ex_rs2          (ex_rs2),
    .ex_pred_taken   (ex_pred_taken),
    .ex_br_taken     (ex_br_taken),
    .ex_mispredict   (ex_mispredict),
    .ex_redirect_pc  (ex_redirect_pc),
    .stat_clr        (stat_clr),
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic        tk;
    logic        mp;
    logic [31:0] rd;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [31:0] a, input logic [31:0] b, input logic pred);
    ex_valid      = 1'b1;
    ex_is_branch  = 1'b1;
    ex_stall      = 1'b0;
    ex_funct3     = f3;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_rs1        = a;
    ex_rs2        = b;
    ex_pred_taken = pred;
  endtask

  task automatic idle();
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_stall     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stat_clr = 1'b0; if_pc = 32'h100;
    idle();
    ex_funct3 = 3'b000; ex_pc = '0; ex_target = '0; ex_rs1 = '0; ex_rs2 = '0; ex_pred_taken = 1'b0;
    step(); step();
    total_cnt++;
    if (if_pred_taken !== 1'b0) $display("FAIL reset_pred_in_reset: got %0b expected 0", if_pred_taken);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (if_pred_taken !== 1'b0) $display("FAIL reset_pred_after: got %0b expected 0", if_pred_taken);
    else pass_cnt++;
  endtask

  task automatic test_conditions();
    vec_t v [9];
    v = '{
      '{3'b000, 32'h100, 32'h200, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1, 32'h200},
      '{3'b100, 32'h100, 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0, 32'h0},
      '{3'b110, 32'h100, 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1, 32'h104},
      '{3'b101, 32'h100, 32'h300, 32'd7, 32'd7, 1'b0, 1'b1, 1'b1, 32'h300},
      '{3'b111, 32'h100, 32'h300, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h104},
      '{3'b001, 32'h100, 32'h300, 32'd5, 32'd6, 1'b0, 1'b1, 1'b1, 32'h300},
      '{3'b101, 32'hFFFF_FFFC, 32'h10, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b1, 32'h0},
      '{3'b110, 32'h100, 32'h400, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0},
      '{3'b001, 32'h100, 32'h400, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0, 32'h0}
    };
    if_pc = 32'h100;
    for (int i = 0; i < 9; i++) begin
      drive_br(v[i].f3, v[i].pc, v[i].tgt, v[i].a, v[i].b, v[i].pred);
      #1;
      $display("cond[%0d] f3=%03b rs1=%08h rs2=%08h taken=%0b mispredict=%0b redirect=%08h",
               i, v[i].f3, v[i].a, v[i].b, ex_br_taken, ex_mispredict, ex_redirect_pc);
      total_cnt++;
      if (ex_br_taken !== v[i].tk)
        $display("FAIL cond_taken[%0d]: got %0b expected %0b", i, ex_br_taken, v[i].tk);
      else pass_cnt++;
      total_cnt++;
      if (ex_mispredict !== v[i].mp)
        $display("FAIL cond_mispredict[%0d]: got %0b expected %0b", i, ex_mispredict, v[i].mp);
      else pass_cnt++;
      if (v[i].mp) begin
        total_cnt++;
        if (ex_redirect_pc !== v[i].rd)
          $display("FAIL cond_redirect[%0d]: got %08h expected %08h", i, ex_redirect_pc, v[i].rd);
        else pass_cnt++;
      end
      step();
    end
    // Equal operands on BEQ but the instruction is a bubble: nothing resolves.
    drive_br(3'b000, 32'h100, 32'h200, 32'd5, 32'd5, 1'b0);
    ex_valid = 1'b0;
    #1;
    total_cnt++;
    if (ex_br_taken !== 1'b0 || ex_mispredict !== 1'b0)
      $display("FAIL cond_bubble: got taken=%0b mispredict=%0b expected 0/0", ex_br_taken, ex_mispredict);
    else pass_cnt++;
    idle();
    step(); step();
  endtask

  task automatic test_saturate_bypass();
    if_pc = 32'h40;
    drive_br(3'b000, 32'h40, 32'h80, 32'd1, 32'd1, 1'b0);
    #1;
    total_cnt++;
    if (if_pred_taken !== 1'b0) $display("FAIL sat_initial: got %0b expected 0", if_pred_taken);
    else pass_cnt++;
    step();
    total_cnt++;
    if (if_pred_taken !== 1'b1) $display("FAIL sat_bypass_first: got %0b expected 1", if_pred_taken);
    else pass_cnt++;
    if_pc = 32'h44;
    #1;
    total_cnt++;
    if (if_pred_taken !== 1'b0) $display("FAIL sat_other_index: got %0b expected 0", if_pred_taken);
    else pass_cnt++;
    if_pc = 32'h40;
    step();
    total_cnt++;
    if (if_pred_taken !== 1'b1) $display("FAIL sat_second: got %0b expected 1", if_pred_taken);
    else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++;
    if (if_pred_taken !== 1'b1) $display("FAIL sat_third_bypass: got %0b expected 1", if_pred_taken);
    else pass_cnt++;
    step();
    total_cnt++;
    if (if_pred_taken !== 1'b1) $display("FAIL sat_hold_11: got %0b expected 1", if_pred_taken);
    else pass_cnt++;
    // Two not-taken outcomes walk 11 -> 10 -> 01.
    drive_br(3'b001, 32'h40, 32'h80, 32'd1, 32'd1, 1'b1);
    step();
    idle();
    #1;
    total_cnt++;
    if (if_pred_taken !== 1'b1) $display("FAIL sat_down_10: got %0b expected 1", if_pred_taken);
    else pass_cnt++;
    step();
    drive_br(3'b001, 32'h40, 32'h80, 32'd1, 32'd1, 1'b1);
    step();
    idle();
    #1;
    total_cnt++;
    if (if_pred_taken !== 1'b0) $display("FAIL sat_down_01_bypass: got %0b expected 0", if_pred_taken);
    else pass_cnt++;
    step();
    total_cnt++;
    if (if_pred_taken !== 1'b0) $display("FAIL sat_down_01: got %0b expected 0", if_pred_taken);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    if_pc = 32'h80;
    drive_br(3'b000, 32'h80, 32'h0, 32'd3, 32'd3, 1'b0);
    ex_stall = 1'b1;
    #1;
    total_cnt++;
    if (ex_br_taken !== 1'b0 || ex_mispredict !== 1'b0)
      $display("FAIL stall_outputs: got taken=%0b mispredict=%0b expected 0/0", ex_br_taken, ex_mispredict);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if (if_pred_taken !== 1'b0)
        $display("FAIL stall_no_update[%0d]: got %0b expected 0", i, if_pred_taken);
      else pass_cnt++;
    end
    ex_stall = 1'b0;
    #1;
    total_cnt++;
    if (ex_br_taken !== 1'b1) $display("FAIL stall_release_taken: got %0b expected 1", ex_br_taken);
    else pass_cnt++;
    step();
    idle();
    #1;
    total_cnt++;
    if (if_pred_taken !== 1'b1) $display("FAIL stall_single_inc: got %0b expected 1", if_pred_taken);
    else pass_cnt++;
    step();
    // One decrement must return to 01 if only one increment happened.
    drive_br(3'b001, 32'h80, 32'h0, 32'd3, 32'd3, 1'b1);
    step();
    idle();
    step();
    total_cnt++;
    if (if_pred_taken !== 1'b0) $display("FAIL stall_exactly_once: got %0b expected 0", if_pred_taken);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    if_pc = 32'hC0;
    drive_br(3'b010, 32'hC0, 32'h0, 32'd9, 32'd9, 1'b1);
    #1;
    total_cnt++;
    if (ex_br_taken !== 1'b0 || ex_mispredict !== 1'b0)
      $display("FAIL illegal_010: got taken=%0b mispredict=%0b expected 0/0", ex_br_taken, ex_mispredict);
    else pass_cnt++;
    step();
    ex_funct3 = 3'b011;
    ex_pred_taken = 1'b0;
    #1;
    total_cnt++;
    if (ex_br_taken !== 1'b0 || ex_mispredict !== 1'b0)
      $display("FAIL illegal_011: got taken=%0b mispredict=%0b expected 0/0", ex_br_taken, ex_mispredict);
    else pass_cnt++;
    step();
    idle();
    step();
    total_cnt++;
    if (if_pred_taken !== 1'b0) $display("FAIL illegal_no_update: got %0b expected 0", if_pred_taken);
    else pass_cnt++;
  endtask

  task automatic test_reset_pending();
    if_pc = 32'h20;
    drive_br(3'b000, 32'h20, 32'h0, 32'd1, 32'd1, 1'b0);
    step();
    rst_n = 1'b0;
    drive_br(3'b000, 32'h20, 32'h55, 32'd2, 32'd2, 1'b0);
    #1;
    total_cnt++;
    if (if_pred_taken !== 1'b0) $display("FAIL rstp_pred_in_reset: got %0b expected 0", if_pred_taken);
    else pass_cnt++;
    total_cnt++;
    if (ex_br_taken !== 1'b1 || ex_redirect_pc !== 32'h55)
      $display("FAIL rstp_comb_in_reset: got taken=%0b redirect=%08h expected 1/00000055", ex_br_taken, ex_redirect_pc);
    else pass_cnt++;
    idle();
    step();
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (if_pred_taken !== 1'b0) $display("FAIL rstp_release: got %0b expected 0", if_pred_taken);
    else pass_cnt++;
    step();
    total_cnt++;
    if (if_pred_taken !== 1'b0) $display("FAIL rstp_counter_01: got %0b expected 0", if_pred_taken);
    else pass_cnt++;
  endtask

  task automatic test_stats();
`ifdef BRANCH_STATS_EN
    idle();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    total_cnt++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0)
      $display("FAIL stats_clear_idle: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      drive_br(3'b000, 32'h200 + 32'(4 * i), 32'h0, 32'd4, 32'd4, (i < 3) ? 1'b0 : 1'b1);
      step();
      if (i == 0) begin
        total_cnt++;
        if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd1)
          $display("FAIL stats_first: got %0d/%0d expected 1/1", stat_branches, stat_mispredicts);
        else pass_cnt++;
      end
    end
    idle();
    #1;
    total_cnt++;
    if (stat_branches !== 32'd10) $display("FAIL stats_branches: got %0d expected 10", stat_branches);
    else pass_cnt++;
    total_cnt++;
    if (stat_mispredicts !== 32'd3) $display("FAIL stats_mispredicts: got %0d expected 3", stat_mispredicts);
    else pass_cnt++;
    drive_br(3'b000, 32'h300, 32'h0, 32'd4, 32'd4, 1'b0);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    idle();
    total_cnt++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0)
      $display("FAIL stats_clear_priority: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
    else pass_cnt++;
`else
    drive_br(3'b000, 32'h300, 32'h0, 32'd4, 32'd4, 1'b0);
    step();
    idle();
    total_cnt++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0)
      $display("FAIL stats_tied_off: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_conditions();
    test_saturate_bypass();
    test_stall();
    test_illegal();
    test_reset_pending();
    test_stats();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
